// File: rtl/muldiv_hilo_if.sv
// muldiv_hilo_if: request/result bundle between the EX stage and the HI/LO mul/div unit.
interface muldiv_hilo_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  modport master (output start, md_op, A_in, B_in, flush, input busy, done, div_zero, hi_out, lo_out);
  modport slave (input start, md_op, A_in, B_in, flush, output busy, done, div_zero, hi_out, lo_out);
endinterface

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative mult/div engine owning the architectural HI/LO registers.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic            clk,
  input logic            rst,
  muldiv_hilo_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t                 state_q, state_d;
  logic [2*WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]       b_q, hi_q, lo_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   div_q, neg_q, rneg_q, zero_q, dz_q;
  logic                   accept, is_md, sa, sb, last;
  logic [WIDTH-1:0]       abs_a, abs_b, rem_n, qv, rv;
  logic [WIDTH:0]         sum, shifted;
  logic                   ge;
  logic [2*WIDTH-1:0]     mul_nx, div_nx, prod, res;
  assign accept  = state_q == IDLE && bus.start && !bus.flush;
  assign is_md   = !bus.md_op[2];
  assign sa      = !bus.md_op[0] && bus.A_in[WIDTH-1];
  assign sb      = !bus.md_op[0] && bus.B_in[WIDTH-1];
  assign abs_a   = sa ? -bus.A_in : bus.A_in;
  assign abs_b   = sb ? -bus.B_in : bus.B_in;
  assign last    = cnt_q == CNT_W'(WIDTH);
  // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
  assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_nx  = {sum, acc_q[WIDTH-1:1]};
  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  assign shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, b_q};
  assign rem_n   = ge ? WIDTH'(shifted - {1'b0, b_q}) : shifted[WIDTH-1:0];
  assign div_nx  = {rem_n, acc_q[WIDTH-2:0], ge};
  assign prod    = neg_q ? -acc_q : acc_q;
  assign qv      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rv      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign res     = div_q ? {rv, qv} : prod;
  assign bus.busy     = state_q != IDLE;
  assign bus.done     = state_q == DONE;
  assign bus.div_zero = state_q == DONE && dz_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = accept && is_md ? CALC : IDLE;
    else if (state_q == CALC) state_d = bus.flush ? IDLE : last ? DONE : CALC;
    else state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && is_md) begin
        acc_q  <= {{WIDTH{1'b0}}, bus.md_op[1] ? abs_a : abs_b};
        b_q    <= bus.md_op[1] ? abs_b : abs_a;
        div_q  <= bus.md_op[1];
        neg_q  <= sa ^ sb;
        rneg_q <= sa;
        zero_q <= bus.B_in == '0;
        cnt_q  <= '0;
      end
      if (accept && bus.md_op == 3'b100) hi_q <= bus.A_in;
      if (accept && bus.md_op == 3'b101) lo_q <= bus.A_in;
      if (state_q == CALC && !bus.flush && !last) begin
        acc_q <= div_q ? div_nx : mul_nx;
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == CALC && !bus.flush && last) begin
        if (!(div_q && zero_q)) {hi_q, lo_q} <= res;
        dz_q <= div_q && zero_q;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: directed tests against an arithmetic reference model of HI/LO and timing.
module tb_muldiv_hilo_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   started = 1'b0;
  muldiv_hilo_if #(.WIDTH(32)) bus ();
  muldiv_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  // Reference model: results from plain arithmetic, timing as a countdown to the done cycle.
  logic [31:0] m_hi, m_lo;
  logic [63:0] p_res;
  logic        p_dz, m_dz, m_done;
  int          m_rem;
  function automatic logic [63:0] model_res(input logic [2:0] op, input logic [31:0] a, b);
    longint sa, sb;
    logic [63:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000: return 64'(sa * sb);
      3'b001: return {32'b0, a} * {32'b0, b};
      3'b010: begin q = 64'(sa / sb); r = 64'(sa % sb); return {r[31:0], q[31:0]}; end
      default: begin q = {32'b0, a / b}; r = {32'b0, a % b}; return {r[31:0], q[31:0]}; end
    endcase
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    started <= 1'b1;
    if (rst) begin
      m_hi <= '0; m_lo <= '0; m_rem <= 0; m_done <= 1'b0; m_dz <= 1'b0; p_dz <= 1'b0; p_res <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_rem > 0) begin
      if (bus.flush) m_rem <= 0;
      else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_dz <= p_dz;
          if (!p_dz) {m_hi, m_lo} <= p_res;
        end
      end
    end else if (bus.start && !bus.flush) begin
      if (bus.md_op == 3'b100) m_hi <= bus.A_in;
      else if (bus.md_op == 3'b101) m_lo <= bus.A_in;
      else if (!bus.md_op[2]) begin
        m_rem <= 33;
        p_dz <= bus.md_op[1] && bus.B_in == 0;
        p_res <= (bus.md_op[1] && bus.B_in == 0) ? 64'b0 : model_res(bus.md_op, bus.A_in, bus.B_in);
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (started) begin
      chk("busy", 64'(bus.busy), 64'(m_rem != 0 || m_done));
      chk("done", 64'(bus.done), 64'(m_done));
      chk("div_zero", 64'(bus.div_zero), 64'(m_done && m_dz));
      chk("hi_out", 64'(bus.hi_out), 64'(m_hi));
      chk("lo_out", 64'(bus.lo_out), 64'(m_lo));
    end
  end
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, b, eh, el, input logic edz);
    int lat, nb;
    logic [31:0] h, l;
    logic dz;
    lat = -1; nb = 0; h = 'x; l = 'x; dz = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.A_in = a; bus.B_in = b;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 40 && bus.busy; i++) begin
      nb++;
      if (bus.done) begin lat = i; h = bus.hi_out; l = bus.lo_out; dz = bus.div_zero; end
      @(negedge clk);
    end
    chk({nm, "_latency"}, 64'(lat), 64'd33);
    chk({nm, "_busy_cycles"}, 64'(nb), 64'd34);
    chk({nm, "_hi"}, 64'(h), 64'(eh));
    chk({nm, "_lo"}, 64'(l), 64'(el));
    chk({nm, "_div_zero"}, 64'(dz), 64'(edz));
  endtask
  initial begin
    bus.start = 1'b0; bus.md_op = '0; bus.A_in = '0; bus.B_in = '0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_hi", 64'(bus.hi_out), 64'd0);
    chk("reset_lo", 64'(bus.lo_out), 64'd0);
    run_op("t1_mult", 3'b000, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("t2_multu", 3'b001, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_op("t3_div", 3'b010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("t3_divu", 3'b011, 32'hFFFFFFF9, 32'h2, 32'h00000001, 32'h7FFFFFFC, 1'b0);
    run_op("ovf_div", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run_op("div_negdivisor", 3'b010, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0);
    run_op("mult_negneg", 3'b000, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0, 32'hF, 1'b0);
    run_op("multu_big", 3'b001, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E, 32'h242D2080, 1'b0);
    // T4: back-to-back mthi/mtlo then divide by zero
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'b100; bus.A_in = 32'h12345678;
    @(negedge clk);
    chk("t4_mthi_hi", 64'(bus.hi_out), 64'h12345678);
    chk("t4_mthi_busy", 64'(bus.busy), 64'd0);
    bus.md_op = 3'b101; bus.A_in = 32'h9ABCDEF0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t4_mtlo_lo", 64'(bus.lo_out), 64'h9ABCDEF0);
    chk("t4_mtlo_busy", 64'(bus.busy), 64'd0);
    run_op("t4_divu0", 3'b011, 32'h5, 32'h0, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    // T5: start while busy is ignored, flush aborts without done
    begin
      int seen_done;
      seen_done = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.md_op = 3'b000; bus.A_in = 32'h1234; bus.B_in = 32'h5678;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (bus.done) seen_done++;
        bus.start = (i == 10); bus.md_op = 3'b011; bus.A_in = 32'h99; bus.B_in = 32'h3;
        bus.flush = (i == 15);
        @(negedge clk);
      end
      bus.start = 1'b0; bus.flush = 1'b0;
      chk("t5_idle_after_flush", 64'(bus.busy), 64'd0);
      repeat (3) begin
        if (bus.done) seen_done++;
        @(negedge clk);
      end
      chk("t5_no_done", 64'(seen_done), 64'd0);
      chk("t5_hi", 64'(bus.hi_out), 64'h12345678);
      chk("t5_lo", 64'(bus.lo_out), 64'h9ABCDEF0);
    end
    // reserved op and flush-with-start in IDLE are both dropped
    bus.start = 1'b1; bus.md_op = 3'b110; bus.A_in = 32'hDEAD;
    @(negedge clk);
    chk("reserved_busy", 64'(bus.busy), 64'd0);
    bus.md_op = 3'b100; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start_hi", 64'(bus.hi_out), 64'h12345678);
    // T6: reset mid-divide, then a fresh multiply
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'b010; bus.A_in = 32'd100; bus.B_in = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_done", 64'(bus.done), 64'd0);
    chk("t6_hi", 64'(bus.hi_out), 64'd0);
    chk("t6_lo", 64'(bus.lo_out), 64'd0);
    run_op("t6_mult", 3'b000, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
